// File: rtl/otter_io_pkg.sv
// Shared constants for the OTTER IOBUS responder: default window base,
// register word indexes, control/status bit positions and timer states.
package otter_io_pkg;

  // Default base of the 64-byte register window (bits [31:6] are decoded).
  localparam logic [31:0] IO_BASE_ADDR = 32'h1100_0000;

  // Register word indexes, i.e. IOBUS_ADDR[5:2] inside the window.
  localparam logic [3:0] REG_SW    = 4'h0;  // 0x00 switches, read-only
  localparam logic [3:0] REG_LEDS  = 4'h1;  // 0x04 LED register
  localparam logic [3:0] REG_TCTRL = 4'h2;  // 0x08 timer control
  localparam logic [3:0] REG_TCMP  = 4'h3;  // 0x0C timer compare
  localparam logic [3:0] REG_TCNT  = 4'h4;  // 0x10 timer count
  localparam logic [3:0] REG_ISTAT = 4'h5;  // 0x14 interrupt status, write-1-to-clear

  // TCTRL bit positions.
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int TCTRL_TIE  = 2;
  localparam int TCTRL_SIE  = 3;

  // ISTAT bit positions.
  localparam int ISTAT_TMR = 0;
  localparam int ISTAT_SW  = 1;

  // Timer run state; T_RUN is what software sees as TCTRL.EN.
  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/otter_io_timer.sv
// Prescaled compare timer: prescaler, TCNT and the idle/run FSM.
// A CPU write to TCTRL or TCNT always takes priority over a tick on the
// same edge and restarts the prescaler.
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        auto_reload,
  input  logic [31:0] tcmp,
  input  logic        ctrl_wr,
  input  logic        ctrl_en,
  input  logic        cnt_wr,
  input  logic [31:0] cnt_data,
  output logic        en,
  output logic [31:0] tcnt,
  output logic        match
);

  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  timer_state_e  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   tcnt_q,  tcnt_d;
  logic          tick;

  assign tick = (state_q == T_RUN) && (presc_q == PS_LAST);
  assign en   = (state_q == T_RUN);
  assign tcnt = tcnt_q;

  // Next-state logic: CPU load first, otherwise advance prescaler and count.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    match   = 1'b0;
    if (ctrl_wr || cnt_wr) begin
      presc_d = '0;
      if (ctrl_wr) state_d = ctrl_en ? T_RUN : T_IDLE;
      if (cnt_wr)  tcnt_d  = cnt_data;
    end else begin
      case (state_q)
        T_RUN: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (tcnt_q == tcmp) begin
              match  = 1'b1;
              tcnt_d = '0;
              if (!auto_reload) state_d = T_IDLE;
            end else begin
              tcnt_d = tcnt_q + 32'd1;
            end
          end
        end
        default: ;  // T_IDLE holds prescaler and count
      endcase
    end
  end

  // State, prescaler and count registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (!RESET_N) begin
      state_q <= T_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: rtl/otter_iobus_responder.sv
// OTTER IOBUS target: address decode, switch synchronizer, LED/timer/status
// registers, registered read mux and registered interrupt level.
module otter_iobus_responder
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR,
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned SW_W      = 16
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [31:0]     IOBUS_ADDR,
  input  logic [31:0]     IOBUS_OUT,
  input  logic            IOBUS_WR,
  output logic [31:0]     IOBUS_IN,
  input  logic [SW_W-1:0] SWITCHES,
  output logic [SW_W-1:0] LEDS,
  output logic            INTR
);

  logic            in_window;
  logic [3:0]      reg_idx;
  logic            wr_leds, wr_tctrl, wr_tcmp, wr_tcnt, wr_istat;
  logic            unused_addr_lsbs;

  logic [SW_W-1:0] sw_meta, sw_sync, sw_prev;
  logic            sw_changed;

  logic [SW_W-1:0] leds_q;
  logic [31:0]     tcmp_q;
  logic            auto_q, tie_q, sie_q;
  logic [1:0]      istat_q, istat_d, istat_clr;

  logic            tmr_en, tmr_match;
  logic [31:0]     tmr_cnt;

  logic [31:0]     rd_data;
  logic            intr_d;

  // Word-aligned bus: the byte offset bits carry no meaning.
  assign unused_addr_lsbs = ^IOBUS_ADDR[1:0];

  assign in_window = (IOBUS_ADDR[31:6] == BASE_ADDR[31:6]);
  assign reg_idx   = IOBUS_ADDR[5:2];
  assign wr_leds   = IOBUS_WR && in_window && (reg_idx == REG_LEDS);
  assign wr_tctrl  = IOBUS_WR && in_window && (reg_idx == REG_TCTRL);
  assign wr_tcmp   = IOBUS_WR && in_window && (reg_idx == REG_TCMP);
  assign wr_tcnt   = IOBUS_WR && in_window && (reg_idx == REG_TCNT);
  assign wr_istat  = IOBUS_WR && in_window && (reg_idx == REG_ISTAT);

  // Two-flop switch synchronizer plus one cycle of history for change detect.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: synchronizer flops are reset as well, so reset release cannot fake a switch change.
    if (!RESET_N) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_prev <= '0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
    end
  end

  assign sw_changed = (sw_sync != sw_prev);

  otter_io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .auto_reload (auto_q),
    .tcmp        (tcmp_q),
    .ctrl_wr     (wr_tctrl),
    .ctrl_en     (IOBUS_OUT[TCTRL_EN]),
    .cnt_wr      (wr_tcnt),
    .cnt_data    (IOBUS_OUT),
    .en          (tmr_en),
    .tcnt        (tmr_cnt),
    .match       (tmr_match)
  );

  // Status update: hardware set beats a same-edge write-1-to-clear.
  assign istat_clr = wr_istat ? IOBUS_OUT[1:0] : 2'b00;
  always_comb begin
    istat_d            = istat_q & ~istat_clr;
    istat_d[ISTAT_TMR] = istat_d[ISTAT_TMR] | tmr_match;
    istat_d[ISTAT_SW]  = istat_d[ISTAT_SW]  | sw_changed;
  end

  // CPU-writable registers and interrupt status.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_q  <= '0;
      tcmp_q  <= '0;
      auto_q  <= 1'b0;
      tie_q   <= 1'b0;
      sie_q   <= 1'b0;
      istat_q <= '0;
    end else begin
      if (wr_leds) leds_q <= IOBUS_OUT[SW_W-1:0];
      if (wr_tcmp) tcmp_q <= IOBUS_OUT;
      if (wr_tctrl) begin
        auto_q <= IOBUS_OUT[TCTRL_AUTO];
        tie_q  <= IOBUS_OUT[TCTRL_TIE];
        sie_q  <= IOBUS_OUT[TCTRL_SIE];
      end
      istat_q <= istat_d;
    end
  end

  assign LEDS = leds_q;

  // Read mux: out-of-window and unmapped offsets return zero.
  always_comb begin
    rd_data = '0;
    if (in_window) begin
      case (reg_idx)
        REG_SW:    rd_data[SW_W-1:0] = sw_sync;
        REG_LEDS:  rd_data[SW_W-1:0] = leds_q;
        REG_TCTRL: begin
          rd_data[TCTRL_EN]   = tmr_en;
          rd_data[TCTRL_AUTO] = auto_q;
          rd_data[TCTRL_TIE]  = tie_q;
          rd_data[TCTRL_SIE]  = sie_q;
        end
        REG_TCMP:  rd_data = tcmp_q;
        REG_TCNT:  rd_data = tmr_cnt;
        REG_ISTAT: rd_data[1:0] = istat_q;
        default:   rd_data = '0;
      endcase
    end
  end

  assign intr_d = (istat_q[ISTAT_TMR] & tie_q) | (istat_q[ISTAT_SW] & sie_q);

  // Registered read data and interrupt level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      IOBUS_IN <= '0;
      INTR     <= 1'b0;
    end else begin
      IOBUS_IN <= rd_data;
      INTR     <= intr_d;
    end
  end

endmodule

// File: tb/tb_otter_iobus_responder.sv
// Directed bench for otter_iobus_responder with PRESCALE=4, SW_W=16.
// Edge numbers in comments count posedges after the named write edge.
module tb_otter_iobus_responder;

  localparam logic [31:0] BASE    = 32'h1100_0000;
  localparam logic [31:0] A_SW    = BASE + 32'h00;
  localparam logic [31:0] A_LEDS  = BASE + 32'h04;
  localparam logic [31:0] A_TCTRL = BASE + 32'h08;
  localparam logic [31:0] A_TCMP  = BASE + 32'h0C;
  localparam logic [31:0] A_TCNT  = BASE + 32'h10;
  localparam logic [31:0] A_ISTAT = BASE + 32'h14;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic        INTR;

  int n_cmp = 0;
  int n_err = 0;

  otter_iobus_responder #(
    .BASE_ADDR (BASE),
    .PRESCALE  (4),
    .SW_W      (16)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .SWITCHES   (SWITCHES),
    .LEDS       (LEDS),
    .INTR       (INTR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle store; takes effect on the next posedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR   = 1'b0;
  endtask

  // Present an address for one edge and check the data captured on it.
  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    IOBUS_ADDR = addr;
    IOBUS_WR   = 1'b0;
    @(posedge CLK);
    #1;
    check(tag, IOBUS_IN, exp);
  endtask

  initial begin
    RESET_N    = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    SWITCHES   = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_iobus_in", IOBUS_IN, 32'h0);
    check("rst_leds", 32'(LEDS), 32'h0);
    check("rst_intr", 32'(INTR), 32'h0);
    RESET_N = 1'b1;
    read_check(A_LEDS,  32'h0, "rst_leds_reg");
    read_check(A_TCTRL, 32'h0, "rst_tctrl");
    read_check(A_TCNT,  32'h0, "rst_tcnt");
    read_check(A_ISTAT, 32'h0, "rst_istat");

    // LED register
    bus_write(A_LEDS, 32'h0000_A5A5);
    check("leds_port", 32'(LEDS), 32'h0000_A5A5);
    read_check(A_LEDS, 32'h0000_A5A5, "leds_read");

    // Out-of-window, unmapped and read-only writes are ignored
    bus_write(32'h1200_0004, 32'h0000_1234);
    bus_write(BASE + 32'h20, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h24, 32'hFFFF_FFFF);
    bus_write(A_SW,          32'hFFFF_FFFF);
    check("oow_leds_kept", 32'(LEDS), 32'h0000_A5A5);
    read_check(32'h1200_0000, 32'h0, "oow_read");
    read_check(32'h1200_0004, 32'h0, "oow_read_alias");
    read_check(BASE + 32'h20, 32'h0, "unmapped_20");
    read_check(BASE + 32'h24, 32'h0, "unmapped_24");
    read_check(A_SW,    32'h0, "sw_ro");
    read_check(A_TCTRL, 32'h0, "oow_tctrl");
    read_check(A_TCMP,  32'h0, "oow_tcmp");
    read_check(A_TCNT,  32'h0, "oow_tcnt");
    read_check(A_ISTAT, 32'h0, "oow_istat");

    // Auto-reload timer: ticks at E4,8,12,16; match on E16, INTR on E17
    bus_write(A_TCMP, 32'd3);
    read_check(A_TCMP, 32'd3, "tcmp_read");
    bus_write(A_TCTRL, 32'h7);                     // E0
    IOBUS_ADDR = A_ISTAT;
    repeat (16) @(posedge CLK);
    #1;                                            // E16
    check("auto_istat_pre", IOBUS_IN, 32'h0);
    check("auto_intr_pre", 32'(INTR), 32'h0);
    @(posedge CLK);
    #1;                                            // E17
    check("auto_istat", IOBUS_IN, 32'h1);
    check("auto_intr", 32'(INTR), 32'h1);
    read_check(A_TCNT,  32'h0, "auto_tcnt_reload"); // E18
    read_check(A_TCTRL, 32'h7, "auto_en_kept");     // E19
    repeat (12) @(posedge CLK);
    #1;                                            // E31
    bus_write(A_ISTAT, 32'h1);                     // E32: next match, same edge
    read_check(A_ISTAT, 32'h1, "set_beats_w1c");   // E33
    check("set_beats_w1c_intr", 32'(INTR), 32'h1);
    bus_write(A_ISTAT, 32'h1);                     // E34
    read_check(A_ISTAT, 32'h0, "w1c_clear");       // E35
    check("w1c_clear_intr", 32'(INTR), 32'h0);
    bus_write(A_TCTRL, 32'h0);                     // E36: tick edge, write wins
    read_check(A_TCNT,  32'h0, "wr_beats_tick");
    read_check(A_TCTRL, 32'h0, "tctrl_stopped");

    // One-shot: match on F4, EN drops, no further matches
    bus_write(A_TCMP, 32'd0);
    bus_write(A_TCTRL, 32'h5);                     // F0
    IOBUS_ADDR = A_ISTAT;
    repeat (4) @(posedge CLK);
    #1;                                            // F4
    check("oneshot_istat_pre", IOBUS_IN, 32'h0);
    @(posedge CLK);
    #1;                                            // F5
    check("oneshot_istat", IOBUS_IN, 32'h1);
    check("oneshot_intr", 32'(INTR), 32'h1);
    read_check(A_TCTRL, 32'h4, "oneshot_tctrl");
    read_check(A_TCNT,  32'h0, "oneshot_tcnt");
    bus_write(A_ISTAT, 32'h1);
    repeat (12) @(posedge CLK);
    #1;
    read_check(A_ISTAT, 32'h0, "oneshot_no_rematch");
    check("oneshot_intr_low", 32'(INTR), 32'h0);

    // 32-bit wrap without an event
    bus_write(A_TCMP, 32'd5);
    bus_write(A_TCNT, 32'hFFFF_FFFF);
    bus_write(A_TCTRL, 32'h1);                     // T0
    IOBUS_ADDR = A_TCNT;
    repeat (4) @(posedge CLK);
    #1;
    check("wrap_pre", IOBUS_IN, 32'hFFFF_FFFF);
    @(posedge CLK);
    #1;
    check("wrap_tcnt", IOBUS_IN, 32'h0);
    read_check(A_ISTAT, 32'h0, "wrap_no_event");

    // Switch change: SW visible after the synchronizer, status bit 1 set
    bus_write(A_TCTRL, 32'h8);                     // S0
    SWITCHES   = 16'h0001;
    IOBUS_ADDR = A_SW;
    repeat (2) @(posedge CLK);
    #1;                                            // S2
    check("sw_sync_lag", IOBUS_IN, 32'h0);
    @(posedge CLK);
    #1;                                            // S3
    check("sw_read", IOBUS_IN, 32'h1);
    read_check(A_ISTAT, 32'h2, "sw_change");       // S4
    check("sw_intr", 32'(INTR), 32'h1);
    bus_write(A_ISTAT, 32'h1);
    read_check(A_ISTAT, 32'h2, "w1c_zero_keeps");
    check("w1c_zero_keeps_intr", 32'(INTR), 32'h1);
    bus_write(A_ISTAT, 32'h2);
    read_check(A_ISTAT, 32'h0, "sw_w1c_clear");
    check("sw_w1c_intr", 32'(INTR), 32'h0);

    // Reset asserted mid-count clears outputs without a clock edge
    bus_write(A_LEDS, 32'h0000_00FF);
    bus_write(A_TCNT, 32'h0);
    bus_write(A_TCMP, 32'h0);
    bus_write(A_TCTRL, 32'h7);                     // R0, match on R4
    IOBUS_ADDR = A_LEDS;
    repeat (6) @(posedge CLK);
    #1;
    check("pre_rst_intr", 32'(INTR), 32'h1);
    check("pre_rst_iobus_in", IOBUS_IN, 32'h0000_00FF);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_iobus_in", IOBUS_IN, 32'h0);
    check("midrst_leds", 32'(LEDS), 32'h0);
    check("midrst_intr", 32'(INTR), 32'h0);
    #3 RESET_N = 1'b1;
    read_check(A_TCTRL, 32'h0, "postrst_tctrl");
    read_check(A_ISTAT, 32'h0, "postrst_istat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
